lcd_display_engine: RTL and testbench

Drives a 16x2 HD44780-compatible character LCD in 8-bit, write-only mode, showing a snapshot of the processor's program counter, output-select code and 32-bit output value. It has two parts. The command sequencer holds the power-up init sequence, the frame layout and hex-to-ASCII conversion. The byte executor generates the RS/RW/EN/DATA bus timing for one byte at a time. The block sits between the CPU datapath and the board LCD pins.

---
 rtl/lcd_display_engine.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_display_engine.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_display_engine.sv
// HD44780 16x2 status display: power-up/init sequencer, PC/SEL/data frame formatter
// and a one-byte RS/RW/EN/DATA bus timing engine, all in one clock domain.
module lcd_display_engine #(
  parameter int EN_CYCLES    = 12,
  parameter int CMD_WAIT     = 2000,
  parameter int CLEAR_WAIT   = 82000,
  parameter int POWERUP_WAIT = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refresh,
  input  logic [7:0]  PC,
  input  logic [3:0]  Out_sel,
  input  logic [31:0] data,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic [7:0]  LCD_DATA,
  output logic        rdy_cmd,
  output logic        rdy_exe,
  output logic [3:0]  state
);

  localparam logic [3:0] S_PWRUP = 4'd0;
  localparam logic [3:0] S_INIT  = 4'd1;
  localparam logic [3:0] S_IDLE  = 4'd2;
  localparam logic [3:0] S_L1A   = 4'd3;
  localparam logic [3:0] S_L1C   = 4'd4;
  localparam logic [3:0] S_L2A   = 4'd5;
  localparam logic [3:0] S_L2C   = 4'd6;

  localparam logic [31:0] LP_PWR_LAST   = 32'(POWERUP_WAIT - 1);
  localparam logic [31:0] LP_EN_LAST    = 32'(EN_CYCLES - 1);
  localparam logic [31:0] LP_CMD_LAST   = 32'(CMD_WAIT - 1);
  localparam logic [31:0] LP_CLEAR_LAST = 32'(CLEAR_WAIT - 1);

  typedef enum logic [1:0] {EX_IDLE, EX_SETUP, EX_EN, EX_WAIT} ex_state_t;

  logic [3:0]  r_state, w_state_next;
  logic [31:0] r_cnt;
  logic [3:0]  r_idx;
  logic        r_pending;
  logic [7:0]  r_pc;
  logic [3:0]  r_sel;
  logic [31:0] r_data;
  logic        w_issue, w_rs, w_rdy_cmd;
  logic [7:0]  w_byte;

  ex_state_t   r_ex_state, w_ex_next;
  logic [31:0] r_ex_cnt;
  logic        r_long_wait, r_lcd_rs;
  logic [7:0]  r_lcd_data;
  logic        w_lcd_en, w_rdy_exe;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // "PC=hh SEL=s     "
  function automatic logic [7:0] line1_char(input logic [3:0] idx, input logic [7:0] pc,
                                            input logic [3:0] sel);
    case (idx)
      4'd0:    return "P";
      4'd1:    return "C";
      4'd2:    return "=";
      4'd3:    return hex_ascii(pc[7:4]);
      4'd4:    return hex_ascii(pc[3:0]);
      4'd6:    return "S";
      4'd7:    return "E";
      4'd8:    return "L";
      4'd9:    return "=";
      4'd10:   return hex_ascii(sel);
      default: return " ";
    endcase
  endfunction

  // "D=hhhhhhhh      ", most significant nibble first
  function automatic logic [7:0] line2_char(input logic [3:0] idx, input logic [31:0] d);
    case (idx)
      4'd0:    return "D";
      4'd1:    return "=";
      4'd2:    return hex_ascii(d[31:28]);
      4'd3:    return hex_ascii(d[27:24]);
      4'd4:    return hex_ascii(d[23:20]);
      4'd5:    return hex_ascii(d[19:16]);
      4'd6:    return hex_ascii(d[15:12]);
      4'd7:    return hex_ascii(d[11:8]);
      4'd8:    return hex_ascii(d[7:4]);
      4'd9:    return hex_ascii(d[3:0]);
      default: return " ";
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_PWRUP;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_pc      <= '0;
      r_sel     <= '0;
      r_data    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= (r_state == S_PWRUP) ? r_cnt + 1 : '0;
      if (w_issue && (r_state == S_INIT || r_state == S_L1C || r_state == S_L2C))
        r_idx <= (r_state == S_INIT && r_idx == 4'd3) ? 4'd0 : r_idx + 4'd1;
      // Any refresh outside IDLE collapses into one pending redraw.
      if (r_state == S_IDLE) begin
        r_pending <= 1'b0;
        if (refresh || r_pending) begin
          r_pc   <= PC;
          r_sel  <= Out_sel;
          r_data <= data;
        end
      end else if (refresh) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_PWRUP: if (r_cnt == LP_PWR_LAST) w_state_next = S_INIT;
      S_INIT:  if (w_issue && r_idx == 4'd3) w_state_next = S_IDLE;
      S_IDLE:  if (refresh || r_pending) w_state_next = S_L1A;
      S_L1A:   if (w_issue) w_state_next = S_L1C;
      S_L1C:   if (w_issue && r_idx == 4'd15) w_state_next = S_L2A;
      S_L2A:   if (w_issue) w_state_next = S_L2C;
      S_L2C:   if (w_issue && r_idx == 4'd15) w_state_next = S_IDLE;
      default: w_state_next = S_PWRUP;
    endcase
  end

  always_comb begin
    w_issue   = 1'b0;
    w_rs      = 1'b0;
    w_byte    = 8'h00;
    w_rdy_cmd = 1'b0;
    case (r_state)
      S_INIT: begin
        w_issue = w_rdy_exe;
        case (r_idx[1:0])
          2'd0:    w_byte = 8'h38;
          2'd1:    w_byte = 8'h0C;
          2'd2:    w_byte = 8'h06;
          default: w_byte = 8'h01;
        endcase
      end
      S_IDLE: w_rdy_cmd = !r_pending;
      S_L1A: begin
        w_issue = w_rdy_exe;
        w_byte  = 8'h80;
      end
      S_L1C: begin
        w_issue = w_rdy_exe;
        w_rs    = 1'b1;
        w_byte  = line1_char(r_idx, r_pc, r_sel);
      end
      S_L2A: begin
        w_issue = w_rdy_exe;
        w_byte  = 8'hC0;
      end
      S_L2C: begin
        w_issue = w_rdy_exe;
        w_rs    = 1'b1;
        w_byte  = line2_char(r_idx, r_data);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_state  <= EX_IDLE;
      r_ex_cnt    <= '0;
      r_long_wait <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
    end else begin
      r_ex_state <= w_ex_next;
      r_ex_cnt   <= (w_ex_next != r_ex_state) ? '0 : r_ex_cnt + 1;
      if (w_issue) begin
        r_lcd_rs    <= w_rs;
        r_lcd_data  <= w_byte;
        r_long_wait <= !w_rs && (w_byte == 8'h01);
      end
    end
  end

  always_comb begin
    w_ex_next = r_ex_state;
    case (r_ex_state)
      EX_IDLE:  if (w_issue) w_ex_next = EX_SETUP;
      EX_SETUP: w_ex_next = EX_EN;
      EX_EN:    if (r_ex_cnt == LP_EN_LAST) w_ex_next = EX_WAIT;
      EX_WAIT:  if (r_ex_cnt == (r_long_wait ? LP_CLEAR_LAST : LP_CMD_LAST)) w_ex_next = EX_IDLE;
      default:  w_ex_next = EX_IDLE;
    endcase
  end

  always_comb begin
    w_lcd_en  = (r_ex_state == EX_EN);
    w_rdy_exe = (r_ex_state == EX_IDLE);
  end

  assign LCD_RS   = r_lcd_rs;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = w_lcd_en;
  assign LCD_DATA = r_lcd_data;
  assign rdy_cmd  = w_rdy_cmd;
  assign rdy_exe  = w_rdy_exe;
  assign state    = r_state;

endmodule

// File: tb/tb_lcd_display_engine.sv
// Self-checking bench for lcd_display_engine: captures bytes on LCD_EN falling edges and
// compares them with a string-built model of the init sequence and screen frames.
module tb_lcd_display_engine;
  localparam int ENC  = 2;
  localparam int CW   = 4;
  localparam int CLW  = 8;
  localparam int PW   = 10;
  localparam int TCLK = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        refresh = 1'b0;
  logic [7:0]  PC = 8'h00;
  logic [3:0]  Out_sel = 4'h0;
  logic [31:0] data = 32'h0;
  logic        LCD_RS, LCD_RW, LCD_EN, rdy_cmd, rdy_exe;
  logic [7:0]  LCD_DATA;
  logic [3:0]  state;

  lcd_display_engine #(
    .EN_CYCLES(ENC), .CMD_WAIT(CW), .CLEAR_WAIT(CLW), .POWERUP_WAIT(PW)
  ) dut (
    .clk(clk), .rst(rst), .refresh(refresh), .PC(PC), .Out_sel(Out_sel), .data(data),
    .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA),
    .rdy_cmd(rdy_cmd), .rdy_exe(rdy_exe), .state(state)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          rw_bad = 0;
  logic [8:0]  cap_q[$];
  logic [8:0]  exp_q[$];
  time         rise_q[$];
  time         width_q[$];
  time         last_rise = 0;
  logic [3:0]  st_q[$];
  string       hexs = "0123456789ABCDEF";

  always @(posedge LCD_EN) begin
    last_rise = $time;
    rise_q.push_back($time);
  end
  always @(negedge LCD_EN) if (rst) begin
    cap_q.push_back({LCD_RS, LCD_DATA});
    width_q.push_back($time - last_rise);
  end
  always @(posedge clk) if (LCD_RW !== 1'b0) rw_bad++;
  always @(state) st_q.push_back(state);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_cmd(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({1'b1, s[i]});
  endtask

  task automatic add_hex(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      int nib;
      nib = int'((v >> (4 * i)) & 32'hF);
      exp_q.push_back({1'b1, hexs[nib]});
    end
  endtask

  task automatic add_init();
    add_cmd(8'h38); add_cmd(8'h0C); add_cmd(8'h06); add_cmd(8'h01);
  endtask

  task automatic add_frame(input logic [7:0] pc, input logic [3:0] sel, input logic [31:0] d);
    add_cmd(8'h80);
    add_str("PC="); add_hex(32'(pc), 2); add_str(" SEL="); add_hex(32'(sel), 1); add_str("     ");
    add_cmd(8'hC0);
    add_str("D="); add_hex(d, 8); add_str("      ");
  endtask

  task automatic clear_q();
    cap_q.delete(); exp_q.delete(); rise_q.delete(); width_q.delete();
  endtask

  // Bytes, EN pulse widths and EN-rise spacing for one contiguous byte stream.
  task automatic compare(input string tag);
    int n;
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    check({tag, "_rises"}, 32'(rise_q.size()), 32'(cap_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    for (int i = 0; i < width_q.size(); i++)
      check($sformatf("%s_enwidth%0d", tag, i), 32'(width_q[i]), 32'(2 * TCLK));
    for (int i = 1; i < rise_q.size() && i < n; i++) begin
      int gap;
      gap = (exp_q[i-1] == 9'h001) ? (2 + ENC + CLW) * TCLK : (2 + ENC + CW) * TCLK;
      check($sformatf("%s_spacing%0d", tag, i), 32'(rise_q[i] - rise_q[i-1]), 32'(gap));
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!(state == 4'd2 && rdy_exe === 1'b1) && k < 3000);
    check({tag, "_reach_idle"}, 32'(state == 4'd2 && rdy_exe === 1'b1), 32'd1);
  endtask

  task automatic wait_cap(input int n);
    int k = 0;
    while (cap_q.size() < n && k < 3000) begin
      @(posedge clk); #1; k++;
    end
    check($sformatf("wait_cap%0d", n), 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic pulse_refresh();
    @(negedge clk) refresh = 1'b1;
    @(negedge clk) refresh = 1'b0;
  endtask

  initial begin
    logic [7:0]  pc_a, pc_b;
    logic [3:0]  sel_a, sel_b;
    logic [31:0] d_a, d_b;
    int          e;

    // Reset values while rst is held low
    #2;
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);
    check("rst_en", 32'(LCD_EN), 32'd0);
    check("rst_data", 32'(LCD_DATA), 32'd0);
    check("rst_rdy_cmd", 32'(rdy_cmd), 32'd0);
    check("rst_rdy_exe", 32'(rdy_exe), 32'd1);
    check("rst_state", 32'(state), 32'd0);

    // Power-up delay and init sequence
    clear_q();
    @(negedge clk) rst = 1'b1;
    e = 0;
    while (LCD_EN !== 1'b1 && e < 100) begin
      @(posedge clk); #1; e++;
    end
    check("pwrup_to_en", 32'(e), 32'(PW + 2));
    wait_idle("init");
    add_init();
    compare("init");
    check("init_rdy_cmd", 32'(rdy_cmd), 32'd1);
    check("init_state", 32'(state), 32'd2);

    // Directed frame with mid-frame input change
    clear_q();
    PC = 8'h3A; Out_sel = 4'hC; data = 32'hDEADBEEF;
    st_q.delete();
    pulse_refresh();
    check("rdy_cmd_fall", 32'(rdy_cmd), 32'd0);
    check("frame1_state_l1a", 32'(state), 32'd3);
    wait_cap(5);
    @(negedge clk) begin PC = 8'h00; data = 32'h01234567; end
    wait_idle("frame1");
    add_frame(8'h3A, 4'hC, 32'hDEADBEEF);
    compare("frame1");
    check("walk_len", 32'(st_q.size()), 32'd5);
    if (st_q.size() == 5) begin
      check("walk0", 32'(st_q[0]), 32'd3);
      check("walk1", 32'(st_q[1]), 32'd4);
      check("walk2", 32'(st_q[2]), 32'd5);
      check("walk3", 32'(st_q[3]), 32'd6);
      check("walk4", 32'(st_q[4]), 32'd2);
    end

    // Randomized frames, inputs scrambled mid-frame
    for (int r = 0; r < 4; r++) begin
      clear_q();
      pc_a = 8'($urandom); sel_a = 4'($urandom); d_a = $urandom;
      PC = pc_a; Out_sel = sel_a; data = d_a;
      pulse_refresh();
      wait_cap(1 + int'($urandom_range(0, 30)));
      PC = 8'($urandom); Out_sel = 4'($urandom); data = $urandom;
      wait_idle($sformatf("rand%0d", r));
      add_frame(pc_a, sel_a, d_a);
      compare($sformatf("rand%0d", r));
    end

    // Three refreshes during a frame give exactly one extra frame
    clear_q();
    pc_a = 8'($urandom); sel_a = 4'($urandom); d_a = $urandom;
    pc_b = 8'($urandom); sel_b = 4'($urandom); d_b = $urandom;
    PC = pc_a; Out_sel = sel_a; data = d_a;
    pulse_refresh();
    wait_cap(3);
    PC = pc_b; Out_sel = sel_b; data = d_b;
    pulse_refresh();
    wait_cap(10);
    pulse_refresh();
    wait_cap(20);
    pulse_refresh();
    wait_idle("pend");
    add_frame(pc_a, sel_a, d_a);
    add_frame(pc_b, sel_b, d_b);
    compare("pend");
    check("pend_rdy_cmd", 32'(rdy_cmd), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("pend_no_more", 32'(cap_q.size()), 32'd68);

    // Asynchronous reset while EN is high mid-character, with a refresh pending
    clear_q();
    pulse_refresh();
    wait_cap(6);
    pulse_refresh();
    e = 0;
    do begin
      @(posedge clk); #2; e++;
    end while (LCD_EN !== 1'b1 && e < 100);
    check("midrst_en_seen", 32'(LCD_EN), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_en", 32'(LCD_EN), 32'd0);
    check("midrst_data", 32'(LCD_DATA), 32'd0);
    check("midrst_rs", 32'(LCD_RS), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_rdy_exe", 32'(rdy_exe), 32'd1);
    check("midrst_rdy_cmd", 32'(rdy_cmd), 32'd0);
    clear_q();
    @(negedge clk) rst = 1'b1;
    wait_idle("reinit");
    add_init();
    compare("reinit");
    check("reinit_rdy_cmd", 32'(rdy_cmd), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("reinit_no_frame", 32'(cap_q.size()), 32'd4);

    // Refresh during init: frame follows 0x01 directly (long clear gap)
    @(negedge clk) rst = 1'b0;
    clear_q();
    pc_a = 8'($urandom); sel_a = 4'($urandom); d_a = $urandom;
    PC = pc_a; Out_sel = sel_a; data = d_a;
    @(negedge clk) rst = 1'b1;
    wait_cap(1);
    pulse_refresh();
    wait_idle("initpend");
    add_init();
    add_frame(pc_a, sel_a, d_a);
    compare("initpend");
    check("initpend_rdy_cmd", 32'(rdy_cmd), 32'd1);

    check("rw_always_low", 32'(rw_bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
